// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdb_arbiter_pkg                                              |
// | Description : Shared types and widths for the common data bus arbiter.     |
// |               Optional statistics build macro: CDB_ARB_STATS_EN            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cdb_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int ARN_W = 5;
  localparam int RRN_W = 6;

  // One result as carried by an execution unit and broadcast on a CDB
  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [ARN_W-1:0] arn;
    logic [RRN_W-1:0] rrn;
    logic             tag;
  } cdb_res_t;

  // 32-bit add that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_multi_picker                                              |
// | Description : Combinational round-robin picker granting up to CDB_CNT of   |
// |               UNIT_CNT requesters, scanning from a start pointer with      |
// |               wrap-around. The k-th granted unit is steered to bus k.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_multi_picker #(
  parameter int UNIT_CNT = 4,
  parameter int CDB_CNT  = 2,
  parameter int PTR_W    = (UNIT_CNT > 1) ? $clog2(UNIT_CNT) : 1
) (
  input  logic [UNIT_CNT-1:0]               req,
  input  logic [PTR_W-1:0]                  start,
  output logic [UNIT_CNT-1:0]               grant,
  output logic [CDB_CNT-1:0][UNIT_CNT-1:0]  bus_sel,
  output logic [PTR_W-1:0]                  last_idx,
  output logic                              any_grant
);

  localparam int SUM_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CDB_CNT + 1);

  logic [SUM_W-1:0] w_sum;
  logic [PTR_W-1:0] w_idx;
  logic [CNT_W-1:0] w_cnt;

  // Walk the units in priority order and hand out buses until they run out
  always_comb begin
    grant     = '0;
    bus_sel   = '0;
    last_idx  = start;
    any_grant = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    w_cnt     = '0;
    for (int i = 0; i < UNIT_CNT; i++) begin
      w_sum = {1'b0, start} + SUM_W'(i);
      if (w_sum >= SUM_W'(UNIT_CNT)) begin
        w_sum = w_sum - SUM_W'(UNIT_CNT);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (req[w_idx] && (w_cnt < CNT_W'(CDB_CNT))) begin
        grant[w_idx] = 1'b1;
        for (int b = 0; b < CDB_CNT; b++) begin
          if (w_cnt == CNT_W'(b)) begin
            bus_sel[b][w_idx] = 1'b1;
          end
        end
        last_idx  = w_idx;
        any_grant = 1'b1;
        w_cnt     = w_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdb_arbiter                                                  |
// | Description : Shares CDB_CNT common data buses among UNIT_CNT execution    |
// |               units with rotating priority; registers winners onto the     |
// |               buses and drops speculative (tagged) results on a flush.     |
// |               Define CDB_ARB_STATS_EN to add grant/stall counters.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int UNIT_CNT = 4,
  parameter int CDB_CNT  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            delete_tagged,
  input  logic [UNIT_CNT-1:0]             req,
  input  cdb_res_t [UNIT_CNT-1:0]         req_res,
  output logic [UNIT_CNT-1:0]             grant,
  output logic [CDB_CNT-1:0]              cdb_valid,
  output cdb_res_t [CDB_CNT-1:0]          cdb_res,
  output logic                            busy
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]                     stat_grants,
  output logic [31:0]                     stat_stall_cycles
`endif
);

  localparam int PTR_W  = (UNIT_CNT > 1) ? $clog2(UNIT_CNT) : 1;
  localparam int CNTU_W = PTR_W + 1;

  logic [PTR_W-1:0]                r_rr_ptr;
  logic [UNIT_CNT-1:0]             w_tag;
  logic [UNIT_CNT-1:0]             w_discard;
  logic [UNIT_CNT-1:0]             w_keep;
  logic [UNIT_CNT-1:0]             w_pick_grant;
  logic [CDB_CNT-1:0][UNIT_CNT-1:0] w_bus_sel;
  logic [PTR_W-1:0]                w_last;
  logic                            w_any_pick;
  logic [PTR_W-1:0]                w_next_ptr;
  cdb_res_t [CDB_CNT-1:0]          w_bus_res;
  logic [CDB_CNT-1:0]              w_bus_valid;

  function automatic logic [CNTU_W-1:0] popcnt(input logic [UNIT_CNT-1:0] v);
    logic [CNTU_W-1:0] n;
    n = '0;
    for (int i = 0; i < UNIT_CNT; i++) begin
      n = n + CNTU_W'(v[i]);
    end
    return n;
  endfunction

  generate
    for (genvar u = 0; u < UNIT_CNT; u++) begin : g_unit_tag
      assign w_tag[u] = req_res[u].tag;
    end
  endgenerate

  // Tagged requests during a flush are acknowledged but never reach a bus
  assign w_discard = delete_tagged ? (req & w_tag) : '0;
  assign w_keep    = req & ~w_discard;

  rr_multi_picker #(
    .UNIT_CNT (UNIT_CNT),
    .CDB_CNT  (CDB_CNT),
    .PTR_W    (PTR_W)
  ) u_picker (
    .req       (w_keep),
    .start     (r_rr_ptr),
    .grant     (w_pick_grant),
    .bus_sel   (w_bus_sel),
    .last_idx  (w_last),
    .any_grant (w_any_pick)
  );

  assign grant      = reset ? (w_pick_grant | w_discard) : '0;
  assign w_next_ptr = (w_last == PTR_W'(UNIT_CNT - 1)) ? '0 : (w_last + PTR_W'(1));

  // Steer each selected unit's payload to its bus; a tagged payload is never valid during a flush
  always_comb begin
    w_bus_res   = '0;
    w_bus_valid = '0;
    for (int b = 0; b < CDB_CNT; b++) begin
      for (int u = 0; u < UNIT_CNT; u++) begin
        if (w_bus_sel[b][u]) begin
          w_bus_res[b] = req_res[u];
        end
      end
      w_bus_valid[b] = (|w_bus_sel[b]) && !(delete_tagged && w_bus_res[b].tag);
    end
  end

  // Bus registers, rotating pointer and congestion flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      cdb_valid <= '0;
      cdb_res   <= '0;
      busy      <= 1'b0;
      r_rr_ptr  <= '0;
    end else begin
      cdb_valid <= w_bus_valid;
      for (int b = 0; b < CDB_CNT; b++) begin
        if (w_bus_valid[b]) begin
          cdb_res[b] <= w_bus_res[b];
        end
      end
      if (w_any_pick) begin
        r_rr_ptr <= w_next_ptr;
      end
      busy <= (popcnt(w_keep) > CNTU_W'(CDB_CNT));
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic w_stall;
  assign w_stall = |(req & ~w_tag & ~w_pick_grant);

  // Saturating broadcast-grant and stall counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_grants       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      stat_grants       <= sat_add32(stat_grants, 32'(popcnt(w_pick_grant)));
      stat_stall_cycles <= sat_add32(stat_stall_cycles, {31'd0, w_stall});
    end
  end
`endif

  a_grant_has_req : assert property (@(posedge clk) disable iff (!reset) ((grant & ~req) == '0));
  a_bus_limit     : assert property (@(posedge clk) disable iff (!reset)
                                     (popcnt(w_pick_grant) <= CNTU_W'(CDB_CNT)));

endmodule
`default_nettype wire
